dac_ramp_gate: RTL and testbench

- Sits directly downstream of the receive DSP core, between its real DAC sample bus and the RF DAC interface.
- Applies a per-channel digital gain, shared across all parallel lanes, to NUMBER_OF_LINE parallel 16-bit samples per clock.
- Gain slews linearly between 0 and a programmable target, so enable, disable and retarget events produce click-free ramps instead of steps.
- Rounds and saturates the scaled samples and reports mute, ramp and saturation status.

---
 rtl/dac_ramp_gate_if.sv | 12 +
 rtl/dac_ramp_gate.sv | 159 +++++++++++++++
 tb/tb_dac_ramp_gate.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ramp_gate_if.sv
// Parallel DAC sample bus between the receive DSP core and the ramp/gain stage.
// master drives samples in and consumes scaled samples; slave is the gain stage.
interface dac_ramp_gate_if #(
    parameter int NUMBER_OF_LINE = 8
);
    logic [16*NUMBER_OF_LINE-1:0] din;
    logic [16*NUMBER_OF_LINE-1:0] dout;
    logic                         sat_flag;

    modport master (output din, input dout, input sat_flag);
    modport slave  (input din, output dout, output sat_flag);
endinterface

// File: rtl/dac_ramp_gate.sv
// Per-channel digital gain with click-free linear gain ramps, rounding and saturation.
// Define DAC_RAMP_SAT_CNT_EN to add the sat_count_clr/sat_count saturation counter.
module dac_ramp_gate #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int GAIN_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    dac_ramp_gate_if.slave    bus,
    input  logic              enable,
    input  logic [GAIN_W-1:0] gain_target,
    input  logic [GAIN_W-1:0] ramp_step,
    output logic              muted,
    output logic              ramp_busy,
    output logic [GAIN_W-1:0] gain_cur
`ifdef DAC_RAMP_SAT_CNT_EN
    ,
    input  logic              sat_count_clr,
    output logic [31:0]       sat_count
`endif
);

    localparam int PW = 17 + GAIN_W;  // signed 16 x zero-extended unsigned gain

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_SLEW      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    localparam logic signed [PW:0] RND_HALF = (PW+1)'(16384);
    localparam logic signed [PW:0] SAT_HI   = (PW+1)'(32767);
    localparam logic signed [PW:0] SAT_LO   = (PW+1)'(-32768);

    logic [1:0]        state, state_n;
    logic [GAIN_W-1:0] gain_n;
    logic [GAIN_W-1:0] step_eff;
    logic [GAIN_W-1:0] slew_gain;
    logic [GAIN_W-1:0] down_gain;
    logic              down_zero;

    assign step_eff  = (ramp_step == '0) ? GAIN_W'(1) : ramp_step;
    assign down_zero = (gain_cur <= step_eff);
    assign down_gain = down_zero ? '0 : gain_cur - step_eff;

    // Clamp each slew step so the gain lands exactly on the target.
    always_comb begin
        slew_gain = gain_cur;
        if (gain_cur < gain_target) begin
            if (gain_target - gain_cur <= step_eff) slew_gain = gain_target;
            else                                   slew_gain = gain_cur + step_eff;
        end else if (gain_cur > gain_target) begin
            if (gain_cur - gain_target <= step_eff) slew_gain = gain_target;
            else                                   slew_gain = gain_cur - step_eff;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        gain_n  = gain_cur;
        case (state)
            ST_MUTED: begin
                gain_n = '0;
                if (enable) state_n = ST_SLEW;
            end
            ST_SLEW: begin
                if (!enable) begin
                    gain_n  = down_gain;
                    state_n = ST_RAMP_DOWN;
                end else begin
                    gain_n = slew_gain;
                    if (slew_gain == gain_target) state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable)                      state_n = ST_RAMP_DOWN;
                else if (gain_target != gain_cur) state_n = ST_SLEW;
            end
            default: begin
                gain_n = down_gain;
                if (enable)         state_n = ST_SLEW;
                else if (down_zero) state_n = ST_MUTED;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_MUTED;
            gain_cur <= '0;
        end else begin
            state    <= state_n;
            gain_cur <= gain_n;
        end
    end

    assign muted     = (state == ST_MUTED);
    assign ramp_busy = (state == ST_SLEW) || (state == ST_RAMP_DOWN);

    logic [16*NUMBER_OF_LINE-1:0] din_s1;
    logic [GAIN_W-1:0]            gain_s1;
    logic signed [PW-1:0]         prod_n  [NUMBER_OF_LINE];
    logic signed [PW-1:0]         prod_s2 [NUMBER_OF_LINE];
    logic signed [PW:0]           rnd     [NUMBER_OF_LINE];
    logic signed [PW:0]           rsh     [NUMBER_OF_LINE];
    logic [16*NUMBER_OF_LINE-1:0] dout_n;
    logic                         sat_n;

    always_comb begin
        for (int k = 0; k < NUMBER_OF_LINE; k++) begin
            prod_n[k] = $signed(din_s1[16*k +: 16]) * $signed({1'b0, gain_s1});
        end
    end

    // Round half up in Q15, then clip to the 16-bit signed DAC range.
    always_comb begin
        dout_n = '0;
        sat_n  = 1'b0;
        for (int k = 0; k < NUMBER_OF_LINE; k++) begin
            rnd[k] = $signed({prod_s2[k][PW-1], prod_s2[k]}) + RND_HALF;
            rsh[k] = rnd[k] >>> 15;
            if (rsh[k] > SAT_HI) begin
                dout_n[16*k +: 16] = 16'h7FFF;
                sat_n              = 1'b1;
            end else if (rsh[k] < SAT_LO) begin
                dout_n[16*k +: 16] = 16'h8000;
                sat_n              = 1'b1;
            end else begin
                dout_n[16*k +: 16] = rsh[k][15:0];
            end
        end
    end

    // NOTE: pipeline data registers are reset too, so dout is clean zero right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_s1       <= '0;
            gain_s1      <= '0;
            bus.dout     <= '0;
            bus.sat_flag <= 1'b0;
            for (int k = 0; k < NUMBER_OF_LINE; k++) prod_s2[k] <= '0;
        end else begin
            din_s1       <= bus.din;
            gain_s1      <= gain_cur;
            bus.dout     <= dout_n;
            bus.sat_flag <= sat_n;
            for (int k = 0; k < NUMBER_OF_LINE; k++) prod_s2[k] <= prod_n[k];
        end
    end

`ifdef DAC_RAMP_SAT_CNT_EN
    always_ff @(posedge clock) begin
        if (reset || sat_count_clr)                 sat_count <= '0;
        else if (bus.sat_flag && sat_count != '1)  sat_count <= sat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dac_ramp_gate.sv
// Self-checking bench for dac_ramp_gate: directed test-plan scenarios plus randomized
// stimulus compared against a behavioural gain/datapath model.
module tb_dac_ramp_gate;

    localparam int NL = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] gain_target;
    logic [15:0] ramp_step;
    logic        muted;
    logic        ramp_busy;
    logic [15:0] gain_cur;
    logic        sat_count_clr;
`ifdef DAC_RAMP_SAT_CNT_EN
    logic [31:0] sat_count;
`endif

    int checks = 0;
    int errors = 0;

    dac_ramp_gate_if #(.NUMBER_OF_LINE(NL)) bus ();

    dac_ramp_gate #(.NUMBER_OF_LINE(NL), .GAIN_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .enable      (enable),
        .gain_target (gain_target),
        .ramp_step   (ramp_step),
        .muted       (muted),
        .ramp_busy   (ramp_busy),
        .gain_cur    (gain_cur)
`ifdef DAC_RAMP_SAT_CNT_EN
        ,
        .sat_count_clr (sat_count_clr),
        .sat_count     (sat_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_MUTED, M_SLEW, M_ACTIVE, M_DOWN} mstate_e;

    mstate_e      m_st;
    int           m_gain;
    logic [127:0] p_dout [3];
    bit           p_sat  [3];
    longint       m_cnt;

    function automatic logic [15:0] ref_lane(input int d, input int g, output bit s);
        longint p, r;
        p = longint'(d) * longint'(g);
        r = (p + 16384) >>> 15;
        s = 1'b0;
        if (r > 32767)       begin s = 1'b1; return 16'h7FFF; end
        else if (r < -32768) begin s = 1'b1; return 16'h8000; end
        return 16'(r);
    endfunction

    task automatic model_edge();
        int s, t, g, d;
        logic [127:0] w;
        bit sat, ls;
        if (reset) begin
            m_st = M_MUTED;
            m_gain = 0;
            m_cnt = 0;
            for (int i = 0; i < 3; i++) begin p_dout[i] = '0; p_sat[i] = 1'b0; end
            return;
        end
        s = (ramp_step == 16'd0) ? 1 : int'(ramp_step);
        t = int'(gain_target);
        g = m_gain;
        if (sat_count_clr)                           m_cnt = 0;
        else if (p_sat[2] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        w = '0;
        sat = 1'b0;
        for (int k = 0; k < NL; k++) begin
            d = int'($signed(bus.din[16*k +: 16]));
            w[16*k +: 16] = ref_lane(d, g, ls);
            sat |= ls;
        end
        p_dout[2] = p_dout[1]; p_sat[2] = p_sat[1];
        p_dout[1] = p_dout[0]; p_sat[1] = p_sat[0];
        p_dout[0] = w;         p_sat[0] = sat;
        case (m_st)
            M_MUTED: begin
                m_gain = 0;
                if (enable) m_st = M_SLEW;
            end
            M_SLEW: begin
                if (!enable) begin
                    m_gain = (g <= s) ? 0 : g - s;
                    m_st = M_DOWN;
                end else begin
                    if (g < t)      m_gain = (g + s > t) ? t : g + s;
                    else if (g > t) m_gain = (g - s < t) ? t : g - s;
                    if (m_gain == t) m_st = M_ACTIVE;
                end
            end
            M_ACTIVE: begin
                if (!enable)     m_st = M_DOWN;
                else if (t != g) m_st = M_SLEW;
            end
            default: begin
                m_gain = (g <= s) ? 0 : g - s;
                if (enable)           m_st = M_SLEW;
                else if (m_gain == 0) m_st = M_MUTED;
            end
        endcase
    endtask

    // Advance one clock; outputs are sampled on the following falling edge.
    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic set_din_all(input logic [15:0] v);
        bus.din = {NL{v}};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; gain_target = 16'h0; ramp_step = 16'h0;
        sat_count_clr = 1'b0;
        set_din_all(16'h1234);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (bus.dout !== 128'h0) begin errors++; $display("FAIL reset_dout cyc %0d got %h exp 0", i, bus.dout); end
            checks++;
            if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted cyc %0d got %b exp 1", i, muted); end
            checks++;
            if (gain_cur !== 16'h0) begin errors++; $display("FAIL reset_gain cyc %0d got %h exp 0", i, gain_cur); end
        end
        checks++;
        if (ramp_busy !== 1'b0 || bus.sat_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy %b sat %b exp 0 0", ramp_busy, bus.sat_flag);
        end
    endtask

    task automatic test_ramp_up();
        enable = 1'b1; gain_target = 16'h8000; ramp_step = 16'h1000;
        tick();
        checks++;
        if (gain_cur !== 16'h0 || ramp_busy !== 1'b1) begin
            errors++; $display("FAIL ramp_enter got gain %h busy %b exp 0000 1", gain_cur, ramp_busy);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (gain_cur !== 16'(i * 16'h1000)) begin
                errors++; $display("FAIL ramp_gain step %0d got %h exp %h", i, gain_cur, 16'(i * 16'h1000));
            end
        end
        checks++;
        if (ramp_busy !== 1'b0 || muted !== 1'b0) begin
            errors++; $display("FAIL ramp_active got busy %b muted %b exp 0 0", ramp_busy, muted);
        end
        repeat (3) tick();
        checks++;
        if (bus.dout !== {NL{16'h1234}}) begin
            errors++; $display("FAIL ramp_unity_dout got %h exp %h", bus.dout, {NL{16'h1234}});
        end
    endtask

    task automatic test_saturation();
        gain_target = 16'hFFFF; ramp_step = 16'hFFFF;
        repeat (2) tick();
        checks++;
        if (gain_cur !== 16'hFFFF || ramp_busy !== 1'b0) begin
            errors++; $display("FAIL sat_gain got %h busy %b exp ffff 0", gain_cur, ramp_busy);
        end
        set_din_all(16'h7000);
        repeat (3) tick();
        checks++;
        if (bus.dout !== {NL{16'h7FFF}} || bus.sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_pos got %h sat %b exp %h 1", bus.dout, bus.sat_flag, {NL{16'h7FFF}});
        end
        set_din_all(16'h8000);
        repeat (3) tick();
        checks++;
        if (bus.dout !== {NL{16'h8000}} || bus.sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_neg got %h sat %b exp %h 1", bus.dout, bus.sat_flag, {NL{16'h8000}});
        end
`ifdef DAC_RAMP_SAT_CNT_EN
        checks++;
        if (sat_count !== 32'(m_cnt) || sat_count == 32'd0) begin
            errors++; $display("FAIL sat_count got %0d exp %0d", sat_count, m_cnt);
        end
`endif
    endtask

    task automatic test_step_clamp();
        logic [15:0] up_seq [3];
        logic [15:0] dn_seq [3];
        up_seq = '{16'h3000, 16'h6000, 16'h8000};
        dn_seq = '{16'h5000, 16'h2000, 16'h0000};
        reset = 1'b1; tick(); reset = 1'b0;
        set_din_all(16'h1234);
        enable = 1'b1; gain_target = 16'h8000; ramp_step = 16'h3000;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gain_cur !== up_seq[i]) begin errors++; $display("FAIL clamp_up %0d got %h exp %h", i, gain_cur, up_seq[i]); end
        end
        checks++;
        if (ramp_busy !== 1'b0) begin errors++; $display("FAIL clamp_active got busy %b exp 0", ramp_busy); end
        enable = 1'b0;
        tick();
        checks++;
        if (gain_cur !== 16'h8000 || ramp_busy !== 1'b1) begin
            errors++; $display("FAIL clamp_down_enter got %h busy %b exp 8000 1", gain_cur, ramp_busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gain_cur !== dn_seq[i] || muted !== (i == 2)) begin
                errors++; $display("FAIL clamp_down %0d got %h muted %b exp %h %b", i, gain_cur, muted, dn_seq[i], i == 2);
            end
        end
    endtask

    task automatic test_zero_step();
        enable = 1'b1; gain_target = 16'd3; ramp_step = 16'd0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (gain_cur !== 16'(i)) begin errors++; $display("FAIL zstep_up %0d got %h exp %h", i, gain_cur, 16'(i)); end
        end
        checks++;
        if (ramp_busy !== 1'b0 || muted !== 1'b0) begin
            errors++; $display("FAIL zstep_active got busy %b muted %b exp 0 0", ramp_busy, muted);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        repeat (2) tick();
        checks++;
        if (gain_cur !== 16'd2 || ramp_busy !== 1'b1) begin
            errors++; $display("FAIL zstep_mid got %h busy %b exp 0002 1", gain_cur, ramp_busy);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (gain_cur !== 16'd1 || ramp_busy !== 1'b1 || muted !== 1'b0) begin
            errors++; $display("FAIL zstep_down1 got %h busy %b muted %b exp 0001 1 0", gain_cur, ramp_busy, muted);
        end
        tick();
        checks++;
        if (gain_cur !== 16'd0 || muted !== 1'b1 || ramp_busy !== 1'b0) begin
            errors++; $display("FAIL zstep_down0 got %h muted %b busy %b exp 0000 1 0", gain_cur, muted, ramp_busy);
        end
    endtask

    task automatic test_reset_mid_rampdown();
        set_din_all(16'h1234);
        enable = 1'b1; gain_target = 16'h8000; ramp_step = 16'h4000;
        repeat (3) tick();
        repeat (3) tick();
        checks++;
        if (bus.dout !== {NL{16'h1234}}) begin
            errors++; $display("FAIL rst_mid_pre got %h exp %h", bus.dout, {NL{16'h1234}});
        end
        enable = 1'b0;
        repeat (2) tick();
        checks++;
        if (gain_cur !== 16'h4000 || ramp_busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_gain got %h busy %b exp 4000 1", gain_cur, ramp_busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (gain_cur !== 16'h0 || muted !== 1'b1 || bus.dout !== 128'h0 || bus.sat_flag !== 1'b0 || ramp_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid got gain %h muted %b dout %h sat %b busy %b exp 0 1 0 0 0",
                               gain_cur, muted, bus.dout, bus.sat_flag, ramp_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) gain_target = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ramp_step = 16'h0;
                    1:       ramp_step = 16'($urandom_range(1, 16'h0400));
                    default: ramp_step = 16'($urandom_range(1, 65535));
                endcase
            end
            sat_count_clr = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NL; k++) bus.din[16*k +: 16] = 16'($urandom);
            tick();
            checks++;
            if (gain_cur !== 16'(m_gain)) begin errors++; $display("FAIL rnd_gain cyc %0d got %h exp %h", c, gain_cur, 16'(m_gain)); end
            checks++;
            if (muted !== (m_st == M_MUTED)) begin errors++; $display("FAIL rnd_muted cyc %0d got %b exp %b", c, muted, m_st == M_MUTED); end
            checks++;
            if (ramp_busy !== (m_st == M_SLEW || m_st == M_DOWN)) begin
                errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, ramp_busy, m_st == M_SLEW || m_st == M_DOWN);
            end
            checks++;
            if (bus.dout !== p_dout[2]) begin errors++; $display("FAIL rnd_dout cyc %0d got %h exp %h", c, bus.dout, p_dout[2]); end
            checks++;
            if (bus.sat_flag !== p_sat[2]) begin errors++; $display("FAIL rnd_sat cyc %0d got %b exp %b", c, bus.sat_flag, p_sat[2]); end
`ifdef DAC_RAMP_SAT_CNT_EN
            checks++;
            if (sat_count !== 32'(m_cnt)) begin errors++; $display("FAIL rnd_satcnt cyc %0d got %0d exp %0d", c, sat_count, m_cnt); end
`endif
        end
        reset = 1'b0;
        sat_count_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        gain_target = '0;
        ramp_step = '0;
        sat_count_clr = 1'b0;
        bus.din = '0;
        @(negedge clock);
        test_reset();
        test_ramp_up();
        test_saturation();
        test_step_clamp();
        test_zero_step();
        test_reset_mid_rampdown();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
